// File: rtl/textbuffer_pkg.sv
// textbuffer_pkg: screen geometry, control codes, plane selects and
// text_console state encoding shared across the textbuffer slice.
package textbuffer_pkg;
    localparam int TB_WIDTH  = 20;
    localparam int TB_HEIGHT = 15;
    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_FF = 8'h0C;
    localparam logic [7:0] CC_CR = 8'h0D;
    localparam logic [7:0] SPACE = 8'h20;
    localparam logic PLANE_CHAR = 1'b0;
    localparam logic PLANE_ATTR = 1'b1;
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_CHAR  = 3'd1;
    localparam logic [2:0] ST_WR_ATTR  = 3'd2;
    localparam logic [2:0] ST_SCR_RD   = 3'd3;
    localparam logic [2:0] ST_SCR_WAIT = 3'd4;
    localparam logic [2:0] ST_SCR_WR   = 3'd5;
    localparam logic [2:0] ST_SCR_CLR  = 3'd6;
    localparam logic [2:0] ST_CLEAR    = 3'd7;
endpackage

// File: rtl/text_console.sv
// text_console: turns a valid/ready byte stream into textbuffer writes,
// tracking a cursor and handling CR/LF/BS/FF, line wrap and scroll.
module text_console
    import textbuffer_pkg::*;
#(
    parameter int         WIDTH      = TB_WIDTH,
    parameter int         HEIGHT     = TB_HEIGHT,
    parameter logic [7:0] CLEAR_ATTR = 8'h0F,
    parameter int         AW         = $clog2(WIDTH*HEIGHT)+1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    input  logic [7:0]    in_attr,
    output logic          tb_cs,
    output logic          tb_rw,
    output logic [AW-1:0] tb_addr,
    output logic [7:0]    tb_di,
    input  logic [7:0]    tb_dout,
    output logic [4:0]    cur_col,
    output logic [3:0]    cur_row,
    output logic          busy
);
    localparam int PW = AW - 1;
    localparam logic [PW-1:0] W_P         = PW'(WIDTH);
    localparam logic [PW-1:0] CELLS_LAST  = PW'(WIDTH*HEIGHT-1);
    localparam logic [PW-1:0] SCROLL_LAST = PW'(WIDTH*(HEIGHT-1)-1);
    localparam logic [4:0]    COL_LAST    = 5'(WIDTH-1);
    localparam logic [3:0]    ROW_LAST    = 4'(HEIGHT-1);

    function automatic logic [PW-1:0] cell_pos(input logic [3:0] r, input logic [4:0] c);
        return PW'(r) * W_P + PW'(c);
    endfunction

    logic [2:0]    state, state_n;
    logic [PW-1:0] idx, idx_n;
    logic          pl, pl_n;
    logic [7:0]    ch, ch_n, at, at_n;
    logic [4:0]    col_n;
    logic [3:0]    row_n;
    logic          cs_n, rw_n;
    logic [AW-1:0] addr_n;
    logic [7:0]    di_n;
    logic          last_row, wrap, done;

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        pl_n     = pl;
        ch_n     = ch;
        at_n     = at;
        col_n    = cur_col;
        row_n    = cur_row;
        last_row = cur_row >= ROW_LAST;
        wrap     = cur_col >= COL_LAST;
        done     = pl && idx == CELLS_LAST;
        case (state)
            ST_IDLE: if (in_valid && in_ready) begin
                ch_n  = in_data;
                at_n  = in_attr;
                idx_n = '0;
                pl_n  = PLANE_CHAR;
                if (in_data == CC_CR)
                    col_n = '0;
                else if (in_data == CC_BS)
                    col_n = cur_col - {4'd0, cur_col != 5'd0};
                else if (in_data == CC_LF) begin
                    col_n   = '0;
                    row_n   = last_row ? cur_row : cur_row + 4'd1;
                    state_n = last_row ? ST_SCR_RD : ST_IDLE;
                end else if (in_data == CC_FF)
                    state_n = ST_CLEAR;
                else
                    state_n = ST_WR_CHAR;
            end
            ST_WR_CHAR: state_n = ST_WR_ATTR;
            ST_WR_ATTR: begin
                col_n   = wrap ? '0 : cur_col + 5'd1;
                row_n   = (wrap && !last_row) ? cur_row + 4'd1 : cur_row;
                state_n = (wrap && last_row) ? ST_SCR_RD : ST_IDLE;
            end
            ST_SCR_RD:   state_n = ST_SCR_WAIT;
            ST_SCR_WAIT: state_n = ST_SCR_WR;
            ST_SCR_WR: begin
                pl_n    = ~pl;
                idx_n   = pl ? idx + 1'b1 : idx;
                state_n = (pl && idx == SCROLL_LAST) ? ST_SCR_CLR : ST_SCR_RD;
            end
            // tb_cs low here only right after reset: the current cell has not been written yet
            ST_SCR_CLR, ST_CLEAR: if (tb_cs) begin
                pl_n    = ~pl;
                idx_n   = (pl && !done) ? idx + 1'b1 : idx;
                state_n = done ? ST_IDLE : state;
                col_n   = (done && state == ST_CLEAR) ? '0 : cur_col;
                row_n   = (done && state == ST_CLEAR) ? '0 : cur_row;
            end
            default: ;
        endcase
        cs_n   = 1'b0;
        rw_n   = 1'b0;
        addr_n = '0;
        di_n   = '0;
        if (state_n == ST_WR_CHAR || state_n == ST_WR_ATTR) begin
            cs_n   = 1'b1;
            rw_n   = 1'b1;
            addr_n = {state_n == ST_WR_ATTR ? PLANE_ATTR : PLANE_CHAR, cell_pos(row_n, col_n)};
            di_n   = state_n == ST_WR_ATTR ? at_n : ch_n;
        end else if (state_n == ST_SCR_RD || state_n == ST_SCR_WAIT) begin
            cs_n   = 1'b1;
            addr_n = {pl_n, idx_n + W_P};
        end else if (state_n == ST_SCR_WR) begin
            cs_n   = 1'b1;
            rw_n   = 1'b1;
            addr_n = {pl_n, idx_n};
            di_n   = tb_dout;
        end else if (state_n == ST_SCR_CLR || state_n == ST_CLEAR) begin
            cs_n   = 1'b1;
            rw_n   = 1'b1;
            addr_n = {pl_n, idx_n};
            di_n   = pl_n ? CLEAR_ATTR : SPACE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_CLEAR;
            idx      <= '0;
            pl       <= PLANE_CHAR;
            ch       <= '0;
            at       <= '0;
            cur_col  <= '0;
            cur_row  <= '0;
            tb_cs    <= 1'b0;
            tb_rw    <= 1'b0;
            tb_addr  <= '0;
            tb_di    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            pl       <= pl_n;
            ch       <= ch_n;
            at       <= at_n;
            cur_col  <= col_n;
            cur_row  <= row_n;
            tb_cs    <= cs_n;
            tb_rw    <= rw_n;
            tb_addr  <= addr_n;
            tb_di    <= di_n;
            in_ready <= state_n == ST_IDLE;
            busy     <= state_n != ST_IDLE;
        end
    end
endmodule

// File: tb/tb_text_console.sv
// tb_text_console: directed checks of text_console driving a textbuffer
// memory model (synchronous read, write on cs & rw).
module tb_text_console;
    import textbuffer_pkg::*;

    logic       clk = 1'b0, reset = 1'b0, in_valid = 1'b0;
    logic [7:0] in_data = 8'h00, in_attr = 8'h00;
    logic       in_ready, tb_cs, tb_rw, busy;
    logic [9:0] tb_addr;
    logic [7:0] tb_di, tb_dout;
    logic [4:0] cur_col;
    logic [3:0] cur_row;
    logic [7:0] mem [0:1023];
    logic [1:0] fill_mode = 2'd0;
    int checks = 0, failures = 0, wr_cnt = 0, cs_cnt = 0;

    always #5 clk = ~clk;

    text_console dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_attr(in_attr), .tb_cs(tb_cs), .tb_rw(tb_rw),
        .tb_addr(tb_addr), .tb_di(tb_di), .tb_dout(tb_dout),
        .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
    );

    // fill_mode 1 poisons every location, 2 loads row r with char r / attr 0x80+r
    always @(posedge clk) begin
        if (fill_mode == 2'd1) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'hAA;
        end else if (fill_mode == 2'd2) begin
            for (int i = 0; i < 300; i++) begin
                mem[i]     <= 8'(i / 20);
                mem[512+i] <= 8'(8'h80 + i / 20);
            end
        end else if (tb_cs && tb_rw) mem[tb_addr] <= tb_di;
        if (tb_cs && !tb_rw) tb_dout <= mem[tb_addr];
        if (tb_cs) cs_cnt <= cs_cnt + 1;
        if (tb_cs && tb_rw) wr_cnt <= wr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input int limit);
        int n = 0;
        while (!in_ready && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] a);
        wait_ready(5000);
        in_valid = 1'b1;
        in_data  = d;
        in_attr  = a;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        int base, bad, n;
        fill_mode = 2'd1;
        @(posedge clk);
        #1 fill_mode = 2'd0;
        @(negedge clk);
        check("rst_bus", {tb_cs, tb_rw, tb_addr, tb_di}, 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_cursor", {cur_row, cur_col}, 32'd0);
        reset = 1'b1;
        base = wr_cnt;
        wait_ready(2000);
        check("clr_writes", wr_cnt - base, 32'd600);
        bad = 0;
        for (int i = 0; i < 300; i++) if (mem[i] !== 8'h20 || mem[512+i] !== 8'h0F) bad++;
        check("clr_cells", bad, 32'd0);
        check("clr_cursor", {cur_row, cur_col}, 32'd0);

        send(8'h41, 8'h1E);
        check("a_char_bus", {tb_cs, tb_rw, tb_addr, tb_di}, {1'b1, 1'b1, 10'h000, 8'h41});
        @(negedge clk);
        check("a_attr_bus", {tb_cs, tb_rw, tb_addr, tb_di}, {1'b1, 1'b1, 10'h200, 8'h1E});
        check("a_ready_mid", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("a_ready", 32'(in_ready), 32'd1);
        check("a_col", 32'(cur_col), 32'd1);

        send(CC_CR, 8'h00);
        for (int k = 0; k < 20; k++) send(8'(8'h41 + k), 8'h07);
        wait_ready(10);
        check("b_pos19", 32'(mem[19]), 32'h54);
        check("b_wrap", {cur_row, cur_col}, {4'd1, 5'd0});
        send(8'h55, 8'h2C);
        wait_ready(10);
        check("b_char21", 32'(mem[10'h014]), 32'h55);
        check("b_attr21", 32'(mem[10'h214]), 32'h2C);

        send(CC_CR, 8'h00);
        send(CC_LF, 8'h00);
        send(CC_LF, 8'h00);
        for (int k = 0; k < 5; k++) send(8'h2E, 8'h07);
        wait_ready(10);
        check("c_at53", {cur_row, cur_col}, {4'd3, 5'd5});
        base = cs_cnt;
        send(CC_BS, 8'h00);
        @(negedge clk);
        check("c_bs_bus", cs_cnt - base, 32'd0);
        check("c_bs", {cur_row, cur_col}, {4'd3, 5'd4});
        send(CC_CR, 8'h00);
        check("c_cr", {cur_row, cur_col}, {4'd3, 5'd0});
        send(CC_LF, 8'h00);
        check("c_lf", {cur_row, cur_col}, {4'd4, 5'd0});

        send(CC_FF, 8'h00);
        wait_ready(2000);
        check("d_home", {cur_row, cur_col}, 32'd0);
        for (int k = 0; k < 14; k++) send(CC_LF, 8'h00);
        wait_ready(10);
        check("d_row14", {cur_row, cur_col}, {4'd14, 5'd0});
        fill_mode = 2'd2;
        @(negedge clk);
        fill_mode = 2'd0;
        send(CC_LF, 8'h00);
        n = 0;
        while (busy && n < 5000) begin
            n++;
            @(negedge clk);
        end
        check("d_busy_cycles", n, 32'd1720);
        bad = 0;
        for (int r = 0; r < 14; r++)
            for (int c = 0; c < 20; c++)
                if (mem[r*20+c] !== 8'(r + 1) || mem[512+r*20+c] !== 8'(8'h81 + r)) bad++;
        for (int c = 280; c < 300; c++) if (mem[c] !== 8'h20 || mem[512+c] !== 8'h0F) bad++;
        check("d_rows", bad, 32'd0);
        check("d_cursor", {cur_row, cur_col}, {4'd14, 5'd0});

        for (int k = 0; k < 19; k++) send(8'h61, 8'h07);
        send(8'h7A, 8'h07);
        wait_ready(5000);
        check("e_last_char", 32'(mem[279]), 32'h7A);
        check("e_last_attr", 32'(mem[512+279]), 32'h07);
        check("e_row0", 32'(mem[0]), 32'h02);
        check("e_clr_row", {mem[299], mem[512+299]}, 32'h200F);
        check("e_cursor", {cur_row, cur_col}, {4'd14, 5'd0});

        send(CC_LF, 8'h00);
        repeat (99) @(negedge clk);
        check("f_mid_cs", 32'(tb_cs), 32'd1);
        check("f_mid_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1 check("f_async_cs", 32'(tb_cs), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        base = wr_cnt;
        wait_ready(2000);
        check("f_clr_writes", wr_cnt - base, 32'd600);
        check("f_cursor", {cur_row, cur_col}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/text_console.md
Name: text_console

Overview:
- Stream-to-screen writer for the textbuffer block. It drives the textbuffer's CPU-side port (cs/rw/addr/di/dout) so that a byte stream becomes on-screen text.
- Accepts one character plus attribute per valid/ready handshake and tracks a cursor. Handles CR, LF, BS and FF, wraps at end of line, and scrolls the screen up one row by copying both planes.
- Sits between a CPU or UART byte source and the textbuffer. It is the only master on the textbuffer port.

Parameters:
- WIDTH, 20, columns per screen.
- HEIGHT, 15, rows per screen.
- CLEAR_ATTR, 8'h0F, attribute written by clear and scroll (low nibble fg, high nibble bg).
- AW, $clog2(WIDTH*HEIGHT)+1, textbuffer address width (derived; 10 at defaults).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  source presents a byte.
- in_ready  out  1  high only in IDLE; transfer occurs when in_valid & in_ready.
- in_data  in  8  character code or control code.
- in_attr  in  8  attribute for a printable character.
- tb_cs  out  1  textbuffer chip select.
- tb_rw  out  1  1 = write, 0 = read.
- tb_addr  out  AW  {plane, pos}; MSB 1 = attribute plane, 0 = character plane; pos = row*WIDTH+col.
- tb_di  out  8  write data.
- tb_dout  in  8  read data; valid the cycle after a read strobe while tb_addr is held.
- cur_col  out  5  cursor column.
- cur_row  out  4  cursor row.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered.
- Reset (async, reset=0):
  - state=CLEAR, cell index 0, cur_col=0, cur_row=0.
  - tb_cs=0, tb_rw=0, tb_addr=0, tb_di=0, in_ready=0, busy=1.
- Bus idle value: whenever no access is issued, tb_cs=0, tb_rw=0, tb_addr=0, tb_di=0.
- States: IDLE, WR_CHAR, WR_ATTR, SCR_RD, SCR_WAIT, SCR_WR, SCR_CLR, CLEAR.
- IDLE: in_ready=1. On a transfer, latch in_data and in_attr. in_valid while busy is ignored and no data is lost.
- Printable bytes (any byte except 0x08, 0x0A, 0x0C, 0x0D):
  - Cycle after accept: WR_CHAR issues cs=1, rw=1, addr={0,pos}, di=char.
  - Next cycle: WR_ATTR issues addr={1,pos}, di=attr.
  - Then advance the cursor. Next accept is possible 3 cycles after the previous accept.
- Cursor advance:
  - col<WIDTH-1: col+1.
  - Otherwise col=0 and the line advances.
- Line advance:
  - row<HEIGHT-1: row+1.
  - Otherwise enter scroll; row stays HEIGHT-1.
- 0x0D (CR): col=0. No bus access; back in IDLE next cycle.
- 0x08 (BS): col-1 if col>0, else unchanged. Never moves up a row and does not erase.
- 0x0A (LF): col=0, then line advance.
- 0x0C (FF): enter CLEAR, then home the cursor to (0,0).
- Scroll, destination i = 0 .. WIDTH*(HEIGHT-1)-1, character plane then attribute plane per cell:
  - SCR_RD: cs=1, rw=0, addr={p, i+WIDTH}.
  - SCR_WAIT: same address held, cs=1, rw=0; capture tb_dout.
  - SCR_WR: cs=1, rw=1, addr={p, i}, di=captured byte.
  - Cost is 3 cycles per plane per cell.
- SCR_CLR: for each last-row cell, write 0x20 to the character plane, then CLEAR_ATTR to the attribute plane (2 cycles per cell). Then IDLE.
- CLEAR: for every cell 0 .. WIDTH*HEIGHT-1, write 0x20 to the character plane, then CLEAR_ATTR to the attribute plane (2 cycles per cell). Then IDLE.
- Arithmetic:
  - pos is AW-1 bits wide; row*WIDTH is computed at full width with no truncation for the default sizes.
  - Cell counters end exactly at their limit and never address beyond WIDTH*HEIGHT-1.
- Boundary cases:
  - Printable at (WIDTH-1, HEIGHT-1): write the cell, then scroll, then cursor=(0, HEIGHT-1).
  - LF at the last row: scroll.
  - FF during any busy state is impossible because in_ready=0.
- Reset mid-operation: the operation aborts immediately (bus outputs drop asynchronously). After release, a full CLEAR runs.

Decomposition:
- Shared package/include textbuffer_pkg:
  - Default WIDTH/HEIGHT.
  - Control codes CC_BS=8'h08, CC_LF=8'h0A, CC_FF=8'h0C, CC_CR=8'h0D.
  - SPACE=8'h20.
  - Plane-select bit positions.
  - State encoding.
- Single module; no sub-module is warranted. The pos multiply-add may be a local function.

Test Plan:
- Reset release, with a textbuffer model attached:
  - Exactly 600 write cycles occur.
  - All char cells are 0x20 and all attr cells are 0x0F.
  - Then in_ready=1 and cursor=(0,0).
- Send 0x41 with attr 0x1E:
  - Bus writes addr 0x000 di 0x41, then addr 0x200 di 0x1E.
  - cur_col=1.
  - in_ready is high again 3 cycles after accept.
- 21 printable bytes from home:
  - The 20th byte lands at pos 19 and the cursor becomes (0,1).
  - The 21st byte writes addr 0x014/0x214.
- At (5,3):
  - Send 0x08: cursor=(4,3) with no bus access.
  - Then 0x0D: col=0.
  - Then 0x0A: cursor=(0,4).
- Fill row r with the byte value r for all rows, then LF at row 14:
  - Busy lasts 280*2*3+20*2=1720 cycles.
  - Model rows 0-13 hold 1-14; row 14 is 0x20/0x0F.
  - Cursor=(0,14).
- Assert reset 100 cycles into a scroll:
  - tb_cs drops to 0 without waiting for a clock edge.
  - After release, a full 600-cycle CLEAR runs and the cursor is (0,0).
